// File: rtl/rename_cam_table.sv
// Rename CAM: per-entry {tag, active}, tag lookups, install/free, active-vector checkpoints.
// Latency: lookups return one cycle after rd_en; writes, free and restore land on the next edge.
// Backpressure: none; clk_en=0 freezes all state and outputs.
module rename_cam_table #(
    parameter int CELLS       = 128,
    parameter int VIRT_COUNT  = 128,
    parameter int WRITE_PORTS = 4,
    parameter int READ_PORTS  = 4,
    parameter int CKPT_COUNT  = 8,
    localparam int VIRT_ADDR_WIDTH = $clog2(VIRT_COUNT),
    localparam int PHYS_ADDR_WIDTH = $clog2(CELLS),
    localparam int CKPT_WIDTH      = $clog2(CKPT_COUNT)
) (
    input  logic                                          clk,
    input  logic                                          sync_rst,
    input  logic                                          clk_en,
    input  logic [WRITE_PORTS-1:0]                        wr_en,
    input  logic [WRITE_PORTS-1:0][PHYS_ADDR_WIDTH-1:0]   wr_addr,
    input  logic [WRITE_PORTS-1:0][VIRT_ADDR_WIDTH-1:0]   wr_tag,
    input  logic                                          free_en,
    input  logic [PHYS_ADDR_WIDTH-1:0]                    free_addr,
    input  logic [READ_PORTS-1:0]                         rd_en,
    input  logic [READ_PORTS-1:0][VIRT_ADDR_WIDTH-1:0]    rd_tag,
    output logic [READ_PORTS-1:0]                         rd_valid,
    output logic [READ_PORTS-1:0]                         rd_hit,
    output logic [READ_PORTS-1:0][PHYS_ADDR_WIDTH-1:0]    rd_addr,
    input  logic                                          ckpt_save,
    input  logic [CKPT_WIDTH-1:0]                         ckpt_save_id,
    input  logic                                          ckpt_restore,
    input  logic [CKPT_WIDTH-1:0]                         ckpt_restore_id,
    output logic                                          ckpt_err
);

    // Architectural state: tags are never reset, only the active bits matter after reset.
    logic [VIRT_ADDR_WIDTH-1:0] tag_q [CELLS];
    logic [CELLS-1:0]           active_q;
    logic [CELLS-1:0]           active_upd;
    logic [CELLS-1:0]           active_d;

    // Checkpoint slots hold only active vectors; tag contents survive a restore.
    logic [CELLS-1:0]           snap_q [CKPT_COUNT];
    logic [CKPT_COUNT-1:0]      ckpt_vld_q;
    logic [CKPT_COUNT-1:0]      ckpt_vld_d;

    // Registered lookup results.
    logic [READ_PORTS-1:0]                      rd_valid_q;
    logic [READ_PORTS-1:0]                      rd_hit_q;
    logic [READ_PORTS-1:0][PHYS_ADDR_WIDTH-1:0] rd_addr_q;
    logic [READ_PORTS-1:0]                      rd_valid_d;
    logic [READ_PORTS-1:0]                      rd_hit_d;
    logic [READ_PORTS-1:0][PHYS_ADDR_WIDTH-1:0] rd_addr_d;
    logic                                       ckpt_err_q;
    logic                                       ckpt_err_d;

    logic [WRITE_PORTS-1:0] wr_win;
    logic                   restore_ok;
    logic                   save_ok;

    assign restore_ok = ckpt_restore && ckpt_vld_q[ckpt_restore_id];
    // A restore in the same cycle suppresses the save.
    assign save_ok    = ckpt_save && !ckpt_restore;

    // A write survives only if no higher-numbered port targets the same entry or the same tag.
    always_comb begin
        wr_win = wr_en;
        for (int i = 0; i < WRITE_PORTS; i++) begin
            for (int j = i + 1; j < WRITE_PORTS; j++) begin
                if (wr_en[j] && ((wr_addr[j] == wr_addr[i]) || (wr_tag[j] == wr_tag[i]))) begin
                    wr_win[i] = 1'b0;
                end
            end
        end
    end

    // Active-vector update: tag-aliasing clears, then free, then installs (install beats free);
    // a restore overrides everything, and an illegal restore leaves the vector untouched.
    always_comb begin
        active_upd = active_q;
        for (int e = 0; e < CELLS; e++) begin
            for (int i = 0; i < WRITE_PORTS; i++) begin
                if (wr_win[i] && (tag_q[e] == wr_tag[i])) begin
                    active_upd[e] = 1'b0;
                end
            end
        end
        if (free_en) begin
            active_upd[free_addr] = 1'b0;
        end
        for (int i = 0; i < WRITE_PORTS; i++) begin
            if (wr_win[i]) begin
                active_upd[wr_addr[i]] = 1'b1;
            end
        end

        if (ckpt_restore) begin
            active_d = restore_ok ? snap_q[ckpt_restore_id] : active_q;
        end else begin
            active_d = active_upd;
        end
    end

    // Checkpoint valid bits: a save marks its slot; a restore never changes any slot.
    always_comb begin
        ckpt_vld_d = ckpt_vld_q;
        if (save_ok) begin
            ckpt_vld_d[ckpt_save_id] = 1'b1;
        end
        ckpt_err_d = ckpt_restore && !ckpt_vld_q[ckpt_restore_id];
    end

    // Lookup against pre-update state; descending scan leaves the lowest matching index.
    always_comb begin
        rd_valid_d = rd_en;
        rd_hit_d   = '0;
        rd_addr_d  = '0;
        for (int j = 0; j < READ_PORTS; j++) begin
            for (int e = CELLS - 1; e >= 0; e--) begin
                if (rd_en[j] && active_q[e] && (tag_q[e] == rd_tag[j])) begin
                    rd_hit_d[j]  = 1'b1;
                    rd_addr_d[j] = PHYS_ADDR_WIDTH'(e);
                end
            end
        end
    end

    // Control state and outputs; reset applies regardless of clk_en.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            active_q   <= '0;
            ckpt_vld_q <= '0;
            rd_valid_q <= '0;
            rd_hit_q   <= '0;
            rd_addr_q  <= '0;
            ckpt_err_q <= 1'b0;
        end else if (clk_en) begin
            active_q   <= active_d;
            ckpt_vld_q <= ckpt_vld_d;
            rd_valid_q <= rd_valid_d;
            rd_hit_q   <= rd_hit_d;
            rd_addr_q  <= rd_addr_d;
            ckpt_err_q <= ckpt_err_d;
        end
    end

    // Tag storage: winning writes land unless a restore discards this cycle's updates.
    always_ff @(posedge clk) begin
        if (!sync_rst && clk_en && !ckpt_restore) begin
            for (int i = 0; i < WRITE_PORTS; i++) begin
                if (wr_win[i]) begin
                    tag_q[wr_addr[i]] <= wr_tag[i];
                end
            end
        end
    end

    // Snapshot storage captures the post-update active vector, including same-cycle writes/free.
    always_ff @(posedge clk) begin
        if (!sync_rst && clk_en && save_ok) begin
            snap_q[ckpt_save_id] <= active_upd;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_hit   = rd_hit_q;
    assign rd_addr  = rd_addr_q;
    assign ckpt_err = ckpt_err_q;

endmodule
